// File: rtl/butterfly_collector_pkg.sv
// butterfly_collector_pkg
//   Shared types and sizing helpers for the butterfly serial collector.
//   - state_t          : collector FSM states (IDLE / COLLECT / DRAIN)
//   - beat_width()     : packed beat width, 2*DW*P*pack_num
//   - pack_cnt_width() : slot counter width, $clog2(pack_num), minimum 1
//   - fifo_cnt_width() : FIFO pointer width, $clog2(depth)+1
//   - *_DEF            : default build sizes
package butterfly_collector_pkg;

    localparam int unsigned DW_DEF         = 16;
    localparam int unsigned P_DEF          = 4;
    localparam int unsigned PACK_NUM_DEF   = 4;
    localparam int unsigned FIFO_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    function automatic int unsigned beat_width(input int unsigned dw,
                                               input int unsigned p,
                                               input int unsigned pn);
        return 2 * dw * p * pn;
    endfunction

    // pack_num = 1 still needs a 1-bit counter to keep the vector legal.
    function automatic int unsigned pack_cnt_width(input int unsigned pn);
        return (pn > 1) ? $clog2(pn) : 1;
    endfunction

    function automatic int unsigned fifo_cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned BEAT_W_DEF = beat_width(DW_DEF, P_DEF, PACK_NUM_DEF);

endpackage

// File: rtl/collector_sync_fifo.sv
// collector_sync_fifo
//   Show-ahead synchronous FIFO for packed beats. A push into a full FIFO is
//   accepted only when a pop happens in the same cycle; otherwise it is lost
//   (the caller detects and reports the drop). o_data reads zero when empty.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (flushes the FIFO)
//   i_push, i_data : write request and data
//   i_pop          : read request (ignored when empty)
//   o_data         : head entry (show-ahead)
//   o_empty, o_full: occupancy flags
module collector_sync_fifo
    import butterfly_collector_pkg::*;
#(
    parameter int unsigned WIDTH = BEAT_W_DEF + 1,
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int unsigned PTR_W = fifo_cnt_width(DEPTH);
    localparam int unsigned AW    = PTR_W - 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             w_pop;
    logic             w_push;

    // Extra pointer MSB distinguishes full from empty.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/butterfly_serial_collector.sv
// butterfly_serial_collector
//   Captures per-lane serial real (A) and imaginary (B) streams, packs
//   pack_num complex samples per lane into one beat, buffers beats in a FIFO
//   and presents them on a valid/ready port. Flags dropped beats and lane
//   valid mismatches, and pulses done when a frame has fully drained.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, length         : frame start pulse, samples per lane
//   in_vld_A/in_dat_A     : serial real valid/data per lane
//   in_vld_B/in_dat_B     : serial imaginary valid/data per lane
//   dn_vld/dn_dat/dn_last : output beat, dn_rdy accepts it
//   overflow, lane_err    : sticky per-frame error flags
//   busy, done            : FSM not idle, frame completion pulse
//   drop_cnt              : saturating dropped-beat count, present only with
//                           BUTTERFLY_COLLECTOR_DROP_CNT_EN defined
module butterfly_serial_collector
    import butterfly_collector_pkg::*;
#(
    parameter int unsigned data_width              = DW_DEF,
    parameter int unsigned parallelism_per_control = P_DEF,
    parameter int unsigned pack_num                = PACK_NUM_DEF,
    parameter int unsigned fifo_depth              = FIFO_DEPTH_DEF
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  start,
    input  logic [15:0]                                           length,
    input  logic [parallelism_per_control-1:0]                    in_vld_A,
    input  logic [data_width*parallelism_per_control-1:0]         in_dat_A,
    input  logic [parallelism_per_control-1:0]                    in_vld_B,
    input  logic [data_width*parallelism_per_control-1:0]         in_dat_B,
    output logic                                                  dn_vld,
    output logic [2*data_width*parallelism_per_control*pack_num-1:0] dn_dat,
    output logic                                                  dn_last,
    input  logic                                                  dn_rdy,
    output logic                                                  overflow,
    output logic                                                  lane_err,
    output logic                                                  busy,
    output logic                                                  done
`ifdef BUTTERFLY_COLLECTOR_DROP_CNT_EN
    ,output logic [15:0]                                          drop_cnt
`endif
);

    localparam int unsigned DW     = data_width;
    localparam int unsigned P      = parallelism_per_control;
    localparam int unsigned PN     = pack_num;
    localparam int unsigned BEAT_W = beat_width(DW, P, PN);
    localparam int unsigned PCW    = pack_cnt_width(PN);
    localparam logic [PCW-1:0] PACK_LAST = PCW'(PN - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_len;
    logic [15:0]       r_sample_cnt;
    logic [PCW-1:0]    r_pack_cnt;
    logic [BEAT_W-1:0] r_pack;
    logic [BEAT_W-1:0] w_beat;
    logic              r_overflow;
    logic              r_lane_err;
    int unsigned       w_slot;
    logic              w_start_ok;
    logic              w_acc;
    logic              w_last_smp;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_lane_bad;
    logic              w_fifo_empty;
    logic              w_fifo_full;

    assign w_start_ok = (r_state == ST_IDLE) & start & (length != '0);
    assign w_acc      = (r_state == ST_COLLECT) & in_vld_A[0] & in_vld_B[0];
    assign w_last_smp = (r_sample_cnt == r_len - 16'd1);
    assign w_push     = w_acc & ((r_pack_cnt == PACK_LAST) | w_last_smp);
    assign w_pop      = dn_rdy & ~w_fifo_empty;
    assign w_drop     = w_push & w_fifo_full & ~w_pop;
    assign w_lane_bad = ~((&in_vld_A) | ~(|in_vld_A)) |
                        ~((&in_vld_B) | ~(|in_vld_B)) |
                        (in_vld_A[0] ^ in_vld_B[0]);

    assign dn_vld   = ~w_fifo_empty;
    assign overflow = r_overflow;
    assign lane_err = r_lane_err;
    assign busy     = (r_state != ST_IDLE);
    assign w_slot   = 32'(r_pack_cnt);

    // The beat offered to the FIFO is the packer plus the sample arriving now,
    // so a completing sample is written in its own acceptance cycle.
    always_comb begin
        w_beat = r_pack;
        for (int unsigned l = 0; l < P; l++) begin
            w_beat[(l*PN + w_slot)*2*DW +: 2*DW] = {in_dat_B[l*DW +: DW], in_dat_A[l*DW +: DW]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        done        = 1'b0;
        case (r_state)
            ST_IDLE:    if (w_start_ok) w_state_nxt = ST_COLLECT;
            ST_COLLECT: if (w_acc && w_last_smp) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (w_fifo_empty) begin
                    w_state_nxt = ST_IDLE;
                    done        = 1'b1;
                end
            end
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len        <= '0;
            r_sample_cnt <= '0;
            r_pack_cnt   <= '0;
            r_pack       <= '0;
            r_overflow   <= 1'b0;
            r_lane_err   <= 1'b0;
        end else if (w_start_ok) begin
            r_len        <= length;
            r_sample_cnt <= '0;
            r_pack_cnt   <= '0;
            r_pack       <= '0;
            r_overflow   <= 1'b0;
            r_lane_err   <= 1'b0;
        end else if (r_state == ST_COLLECT) begin
            if (w_lane_bad) r_lane_err <= 1'b1;
            if (w_drop)     r_overflow <= 1'b1;
            if (w_acc) begin
                r_sample_cnt <= r_sample_cnt + 16'd1;
                if (w_push) begin
                    // Clearing here leaves unused slots of a partial beat zero.
                    r_pack_cnt <= '0;
                    r_pack     <= '0;
                end else begin
                    r_pack_cnt <= r_pack_cnt + PCW'(1);
                    r_pack     <= w_beat;
                end
            end
        end
    end

`ifdef BUTTERFLY_COLLECTOR_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          drop_cnt <= '0;
        else if (w_start_ok)                 drop_cnt <= '0;
        else if (w_drop && drop_cnt != '1)   drop_cnt <= drop_cnt + 16'd1;
    end
`endif

    collector_sync_fifo #(
        .WIDTH (BEAT_W + 1),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({w_last_smp, w_beat}),
        .i_pop   (w_pop),
        .o_data  ({dn_last, dn_dat}),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

endmodule

// File: tb/tb_butterfly_serial_collector.sv
// Testbench for butterfly_serial_collector (default sizes: DW=16, P=4,
// pack_num=4, fifo_depth=8). Expected beats are queued as frames are issued;
// a monitor pops and compares on every dn_vld & dn_rdy.
module tb_butterfly_serial_collector;

    localparam int unsigned DW = 16;
    localparam int unsigned P  = 4;
    localparam int unsigned PN = 4;
    localparam int unsigned FD = 8;
    localparam int unsigned BW = 2 * DW * P * PN;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [15:0]       length;
    logic [P-1:0]      in_vld_A, in_vld_B;
    logic [DW*P-1:0]   in_dat_A, in_dat_B;
    logic              dn_vld, dn_last, dn_rdy;
    logic [BW-1:0]     dn_dat;
    logic              overflow, lane_err, busy, done;
`ifdef BUTTERFLY_COLLECTOR_DROP_CNT_EN
    logic [15:0]       drop_cnt;
`endif

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          pop_cnt = 0;
    int          pop_cyc[$];
    logic [BW:0] sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    butterfly_serial_collector #(
        .data_width              (DW),
        .parallelism_per_control (P),
        .pack_num                (PN),
        .fifo_depth              (FD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .length   (length),
        .in_vld_A (in_vld_A),
        .in_dat_A (in_dat_A),
        .in_vld_B (in_vld_B),
        .in_dat_B (in_dat_B),
        .dn_vld   (dn_vld),
        .dn_dat   (dn_dat),
        .dn_last  (dn_last),
        .dn_rdy   (dn_rdy),
        .overflow (overflow),
        .lane_err (lane_err),
        .busy     (busy),
        .done     (done)
`ifdef BUTTERFLY_COLLECTOR_DROP_CNT_EN
        ,.drop_cnt(drop_cnt)
`endif
    );

    // Lane l sample k = {imag = 0x100+k, real = k+16*l}; slots past L are zero.
    function automatic logic [BW:0] exp_beat(input int unsigned L, input int unsigned b);
        logic [BW-1:0] d;
        int unsigned   nb;
        int unsigned   k;
        d  = '0;
        nb = (L + PN - 1) / PN;
        for (int unsigned l = 0; l < P; l++)
            for (int unsigned s = 0; s < PN; s++) begin
                k = b * PN + s;
                if (k < L) d[(l*PN + s)*2*DW +: 2*DW] = {16'(32'h100 + k), 16'(k + 16*l)};
            end
        return {(b == nb - 1), d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard comparison of every accepted beat.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                done_cnt++;
                chk("busy_at_done", busy, 1);
            end
            if (dn_vld && dn_rdy) begin
                logic [BW:0] e;
                pop_cnt++;
                pop_cyc.push_back(cyc);
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got last=%0d dat=0x%0h expected no beat", dn_last, dn_dat);
                end else begin
                    e = sb_q.pop_front();
                    if ({dn_last, dn_dat} !== e) begin
                        errors++;
                        $display("FAIL beat: got 0x%0h expected 0x%0h", {dn_last, dn_dat}, e);
                    end
                end
            end
        end
    end

    task automatic do_start(input logic [15:0] len);
        start  = 1'b1;
        length = len;
        @(posedge clk); #1;
        start  = 1'b0;
        length = '0;
    endtask

    task automatic drive_sample(input int unsigned k);
        in_vld_A = '1;
        in_vld_B = '1;
        for (int unsigned l = 0; l < P; l++) begin
            in_dat_A[l*DW +: DW] = 16'(k + 16*l);
            in_dat_B[l*DW +: DW] = 16'(32'h100 + k);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_in();
        in_vld_A = '0;
        in_vld_B = '0;
        in_dat_A = '0;
        in_dat_B = '0;
    endtask

    task automatic queue_frame(input int unsigned L, input int unsigned nkeep);
        for (int unsigned b = 0; b < nkeep; b++) sb_q.push_back(exp_beat(L, b));
    endtask

    task automatic wait_done(input int n0, input string name);
        int k;
        k = 0;
        while (done_cnt == n0 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk(name, done_cnt > n0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, pc0, t0;
        rst_n = 1'b0; start = 1'b0; length = '0; dn_rdy = 1'b1;
        idle_in();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dn_vld",   dn_vld, 0);
        chk("rst_dn_dat",   |dn_dat, 0);
        chk("rst_dn_last",  dn_last, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_lane_err", lane_err, 0);
        chk("rst_busy",     busy, 0);
        chk("rst_done",     done, 0);
`ifdef BUTTERFLY_COLLECTOR_DROP_CNT_EN
        chk("rst_drop_cnt", drop_cnt, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Mismatched valids while idle are ignored.
        in_vld_A = 4'b0101;
        repeat (2) @(posedge clk);
        #1; idle_in();
        chk("idle_lane_err", lane_err, 0);

        // Frame 1: length 8, two full beats, dn_rdy high.
        queue_frame(8, 2);
        n0 = done_cnt; pc0 = pop_cyc.size();
        do_start(8);
        chk("f1_busy", busy, 1);
        t0 = cyc;
        for (int k = 0; k < 8; k++) drive_sample(k);
        idle_in();
        wait_done(n0, "f1_done_timeout");
        repeat (4) @(posedge clk); #1;
        chk("f1_beats", pop_cyc.size() - pc0, 2);
        if (pop_cyc.size() >= pc0 + 2) begin
            chk("f1_beat0_lat", pop_cyc[pc0] - t0, 4);
            chk("f1_beat1_lat", pop_cyc[pc0+1] - t0, 8);
        end
        chk("f1_done_once", done_cnt - n0, 1);
        chk("f1_overflow", overflow, 0);
        chk("f1_lane_err", lane_err, 0);
        chk("f1_idle", busy, 0);

        // Frame 2: length 6, partial final beat.
        queue_frame(6, 2);
        n0 = done_cnt;
        do_start(6);
        for (int k = 0; k < 6; k++) drive_sample(k);
        idle_in();
        wait_done(n0, "f2_done_timeout");
        chk("f2_sb_empty", sb_q.size(), 0);

        // Frame 3: dn_rdy low, length 40 -> beats 9 and 10 dropped.
        dn_rdy = 1'b0;
        queue_frame(40, FD);
        n0 = done_cnt;
        do_start(40);
        for (int k = 0; k < 40; k++) drive_sample(k);
        idle_in();
        @(negedge clk);
        chk("f3_overflow", overflow, 1);
        chk("f3_dn_vld", dn_vld, 1);
        chk("f3_head_last", dn_last, 0);
`ifdef BUTTERFLY_COLLECTOR_DROP_CNT_EN
        chk("f3_drop_cnt", drop_cnt, 2);
`endif
        repeat (5) @(posedge clk); #1;
        chk("f3_busy_drain", busy, 1);
        chk("f3_no_early_done", done_cnt - n0, 0);
        pc0 = pop_cnt;
        dn_rdy = 1'b1;
        wait_done(n0, "f3_done_timeout");
        chk("f3_drained", pop_cnt - pc0, FD);
        chk("f3_sb_empty", sb_q.size(), 0);
        // start with length 0 in IDLE is ignored: flags keep their values.
        do_start(0);
        repeat (3) @(posedge clk); #1;
        chk("len0_busy", busy, 0);
        chk("len0_overflow_kept", overflow, 1);
`ifdef BUTTERFLY_COLLECTOR_DROP_CNT_EN
        chk("len0_drop_cnt_kept", drop_cnt, 2);
`endif

        // Frame 4: one COLLECT cycle with in_vld_A = 1110.
        queue_frame(8, 2);
        n0 = done_cnt;
        do_start(8);
        chk("f4_overflow_cleared", overflow, 0);
        drive_sample(0);
        drive_sample(1);
        in_vld_A = 4'b1110;
        in_vld_B = '1;
        @(posedge clk); #1;
        chk("f4_lane_err_set", lane_err, 1);
        for (int k = 2; k < 8; k++) drive_sample(k);
        idle_in();
        wait_done(n0, "f4_done_timeout");
        chk("f4_lane_err_sticky", lane_err, 1);
        chk("f4_sb_empty", sb_q.size(), 0);

        // Frame 5: reset with 3 beats queued, then a normal frame.
        dn_rdy = 1'b0;
        n0 = done_cnt;
        do_start(40);
        chk("f5_lane_err_cleared", lane_err, 0);
        for (int k = 0; k < 12; k++) drive_sample(k);
        idle_in();
        chk("f5_queued_vld", dn_vld, 1);
        rst_n = 1'b0;
        #2;
        chk("f5_rst_dn_vld", dn_vld, 0);
        chk("f5_rst_dn_dat", |dn_dat, 0);
        chk("f5_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("f5_no_done", done_cnt - n0, 0);
        chk("f5_still_empty", dn_vld, 0);
        dn_rdy = 1'b1;
        queue_frame(8, 2);
        n0 = done_cnt;
        do_start(8);
        for (int k = 0; k < 8; k++) drive_sample(k);
        idle_in();
        wait_done(n0, "f5_done_timeout");
        chk("f5_sb_empty", sb_q.size(), 0);

        // Frame 6: start during DRAIN is ignored.
        dn_rdy = 1'b0;
        queue_frame(8, 2);
        n0 = done_cnt;
        do_start(8);
        for (int k = 0; k < 8; k++) drive_sample(k);
        idle_in();
        do_start(4);
        chk("f6_busy_drain", busy, 1);
        dn_rdy = 1'b1;
        wait_done(n0, "f6_done_timeout");
        repeat (4) @(posedge clk); #1;
        chk("f6_not_restarted", busy, 0);
        chk("f6_done_once", done_cnt - n0, 1);
        chk("f6_sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
